// File: rtl/vga_timing_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_decoder
// Purpose  : Receive-side VGA timing recovery. Samples HS/VS on the pixel
//            strobe, measures line length and lines per frame, locks onto a
//            stable frame and reports active-window pixel coordinates.
// Ports    : clk, reset (sync, active-high), pix_en (pixel strobe),
//            hs_in/vs_in (active-high syncs) ->
//            x/y (active coordinates), active, line_start/frame_start
//            (one-clk edge pulses), locked, h_period, v_lines, err (lock lost)
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_decoder #(
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int H_ACTIVE   = 640,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int V_ACTIVE   = 480,
  parameter int LOCK_LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_period,
  output logic [9:0]  v_lines,
  output logic        err
);

  localparam int              c_MW      = $clog2(LOCK_LINES + 1);
  localparam logic [c_MW-1:0] c_LOCK    = c_MW'(LOCK_LINES);
  localparam logic [10:0]     c_H_FIRST = 11'(H_SYNC + H_BP);
  localparam logic [10:0]     c_H_LAST  = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]      c_V_FIRST = 10'(V_SYNC + V_BP);
  localparam logic [9:0]      c_V_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [10:0]     c_H_MAX   = 11'h7FF;
  localparam logic [9:0]      c_V_MAX   = 10'h3FF;

  localparam logic [1:0] c_ST_SEARCH  = 2'd0;
  localparam logic [1:0] c_ST_ACQUIRE = 2'd1;
  localparam logic [1:0] c_ST_LOCKED  = 2'd2;

  logic            r_hs_q, r_vs_q;
  logic [10:0]     r_h_cnt, r_prev_period, r_h_period;
  logic [9:0]      r_v_cnt, r_v_lines;
  logic [c_MW-1:0] r_match;
  logic [1:0]      r_state, w_state_next;
  logic            r_err, w_err_next;
  logic [9:0]      r_x, r_y;
  logic            r_active, r_line_start, r_frame_start;

  logic            w_hs_rise, w_vs_rise, w_hs_lost, w_h_bad, w_v_bad, w_in_window;
  logic [10:0]     w_h_len, w_h_next;
  logic [9:0]      w_v_len, w_v_next;

  // Edge detection is already qualified by the pixel strobe.
  assign w_hs_rise = pix_en & hs_in & ~r_hs_q;
  assign w_vs_rise = pix_en & vs_in & ~r_vs_q;

  // Length of the line/frame that ends at this edge (current index + 1).
  assign w_h_len = r_h_cnt + 11'd1;
  assign w_v_len = r_v_cnt + 10'd1;

  assign w_h_next = w_hs_rise ? 11'd0 :
                    ((r_h_cnt == c_H_MAX) ? c_H_MAX : w_h_len);
  // A VS edge wins over a coincident HS edge: that line becomes line 0.
  assign w_v_next = w_vs_rise ? 10'd0 :
                    (w_hs_rise ? ((r_v_cnt == c_V_MAX) ? c_V_MAX : w_v_len) : r_v_cnt);

  // HS considered lost once the pixel index parks at its ceiling.
  assign w_hs_lost = pix_en & (w_h_next == c_H_MAX);
  assign w_h_bad   = w_hs_rise & (w_h_len != r_prev_period);
  assign w_v_bad   = w_vs_rise & (w_v_len != r_v_lines);

  // Evaluated on the advanced indices so x/y line up with the new h_cnt.
  // Every transition into or out of LOCKED lands on index 0 or 2047,
  // outside the window, so the present state is sufficient here.
  assign w_in_window = (w_h_next >= c_H_FIRST) && (w_h_next <= c_H_LAST) &&
                       (w_v_next >= c_V_FIRST) && (w_v_next <= c_V_LAST) &&
                       (r_state == c_ST_LOCKED);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_SEARCH;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    case (r_state)
      c_ST_SEARCH: begin
        if (w_vs_rise) w_state_next = c_ST_ACQUIRE;
      end
      c_ST_ACQUIRE: begin
        if (w_hs_lost)
          w_state_next = c_ST_SEARCH;
        else if (w_vs_rise && (r_match == c_LOCK))
          w_state_next = c_ST_LOCKED;
      end
      c_ST_LOCKED: begin
        if (w_h_bad || w_v_bad || w_hs_lost) begin
          w_state_next = c_ST_SEARCH;
          w_err_next   = 1'b1;
        end
      end
      default: w_state_next = c_ST_SEARCH;
    endcase
  end

  // Output logic
  always_comb begin
    locked      = (r_state == c_ST_LOCKED);
    err         = r_err;
    x           = r_x;
    y           = r_y;
    active      = r_active;
    line_start  = r_line_start;
    frame_start = r_frame_start;
    h_period    = r_h_period;
    v_lines     = r_v_lines;
  end

  // Measurement datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_q        <= 1'b0;
      r_vs_q        <= 1'b0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_prev_period <= '0;
      r_h_period    <= '0;
      r_v_lines     <= '0;
      r_match       <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= w_hs_rise;
      r_frame_start <= w_vs_rise;
      if (pix_en) begin
        r_hs_q   <= hs_in;
        r_vs_q   <= vs_in;
        r_h_cnt  <= w_h_next;
        r_v_cnt  <= w_v_next;
        r_active <= w_in_window;
        r_x      <= w_in_window ? 10'(w_h_next - c_H_FIRST) : 10'd0;
        r_y      <= w_in_window ? (w_v_next - c_V_FIRST) : 10'd0;
      end
      if (w_hs_rise) begin
        r_h_period    <= w_h_len;
        r_prev_period <= w_h_len;
      end
      if (w_vs_rise) r_v_lines <= w_v_len;
      // Acquisition restarts its line-match run from the frame edge.
      if ((r_state == c_ST_SEARCH) && w_vs_rise)
        r_match <= '0;
      else if (w_hs_rise)
        r_match <= (w_h_len == r_prev_period) ?
                   ((r_match == c_LOCK) ? r_match : r_match + 1'b1) : '0;
    end
  end

endmodule
`default_nettype wire
